// File: rtl/umai_pkg.sv
// Shared lane-word field positions and command payload type for the UMAI link receiver.
package umai_pkg;
  localparam int CMD_BIT         = 71;
  localparam int WR_BIT          = 70;
  localparam int DVALID_BIT      = 64;
  localparam int LANE_W          = 72;
  localparam int WORD_W          = 64;
  localparam int UMAI_BEAT_SLOTS = 8;
  localparam int BEAT_W          = WORD_W * UMAI_BEAT_SLOTS;

  typedef struct packed {
    logic [5:0]  len;
    logic [31:0] addr;
  } umai_cmd_t;
endpackage

// File: rtl/gen_fifo.sv
// Generic synchronous FIFO; accepts a push while full when the head is popped in the same cycle.
module gen_fifo #(
  parameter int Width = 38,
  parameter int Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] din_i,
  output logic             ready_o,
  output logic             valid_o,
  input  logic             pop_i,
  output logic [Width-1:0] dout_o
);
  localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q;
  logic             empty, full, do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(Depth - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(Depth));
  assign do_pop  = pop_i & ~empty;
  assign ready_o = ~full | do_pop;
  assign do_push = push_i & ready_o;
  assign valid_o = ~empty;
  // Head reads as zero while empty so the payload outputs are clean out of reset.
  assign dout_o  = empty ? '0 : mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= ptr_inc(wptr_q);
      if (do_pop)  rptr_q <= ptr_inc(rptr_q);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end
endmodule

// File: rtl/umai_beat_packer.sv
// Packs 64-bit lane words into 512-bit beats; only whole beats reach the beat register.
module umai_beat_packer
  import umai_pkg::*;
#(
  parameter int NumWords = 6
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             push_i,
  input  logic [NumWords-1:0][WORD_W-1:0]  words_i,
  input  logic [NumWords-1:0]              wmask_i,
  output logic                             room_o,
  output logic                             wvalid_o,
  input  logic                             wready_i,
  output logic [BEAT_W-1:0]                wdata_o
);
  logic [2:0]                              ptr_q, ptr_d;
  logic [UMAI_BEAT_SLOTS-1:0][WORD_W-1:0]  asm_q, asm_d;
  logic [BEAT_W-1:0]                       beat_q, beat_d;
  logic                                    full_q, full_d;
  logic [2*UMAI_BEAT_SLOTS-1:0][WORD_W-1:0] slots;
  logic [3:0]                              cnt, pos, sum;
  logic                                    complete;

  // Slots 8..15 hold the overflow that starts the next beat.
  always_comb begin
    slots = '0;
    slots[UMAI_BEAT_SLOTS-1:0] = asm_q;
    cnt = '0;
    pos = '0;
    for (int k = 0; k < NumWords; k++) begin
      if (wmask_i[k]) begin
        pos        = {1'b0, ptr_q} + cnt;
        slots[pos] = words_i[k];
        cnt        = cnt + 4'd1;
      end
    end
    sum      = {1'b0, ptr_q} + cnt;
    complete = sum[3];
    room_o   = ~complete | ~full_q | wready_i;

    asm_d  = asm_q;
    ptr_d  = ptr_q;
    beat_d = beat_q;
    full_d = full_q & ~wready_i;
    if (push_i) begin
      ptr_d = sum[2:0];
      if (complete) begin
        beat_d = slots[UMAI_BEAT_SLOTS-1:0];
        full_d = 1'b1;
        asm_d  = slots[2*UMAI_BEAT_SLOTS-1:UMAI_BEAT_SLOTS];
      end else begin
        asm_d  = slots[UMAI_BEAT_SLOTS-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q  <= '0;
      full_q <= 1'b0;
      beat_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      full_q <= full_d;
      beat_q <= beat_d;
    end
  end

  always_ff @(posedge clk_i) begin
    asm_q <= asm_d;
  end

  assign wvalid_o = full_q;
  assign wdata_o  = beat_q;
endmodule

// File: rtl/umai_link_rx.sv
// Far-side UMAI-over-AIB receiver: splits command and data lanes, queues commands,
// and reassembles data words into 512-bit write beats.
module umai_link_rx
  import umai_pkg::*;
#(
  parameter int NumChannels = 6,
  parameter int CmdDepth    = 2
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [2:0]                         c_first_chn_id,
  input  logic [2:0]                         c_last_chn_id,
  input  logic [NumChannels-1:0]             i_rx_valid,
  output logic [NumChannels-1:0]             o_rx_ready,
  input  logic [NumChannels-1:0][LANE_W-1:0] i_rx_data,
  output logic                               o_umai_wcmd_valid,
  input  logic                               i_umai_wcmd_ready,
  output logic [31:0]                        o_umai_wcmd_addr,
  output logic [5:0]                         o_umai_wcmd_len,
  output logic                               o_umai_rcmd_valid,
  input  logic                               i_umai_rcmd_ready,
  output logic [31:0]                        o_umai_rcmd_addr,
  output logic [5:0]                         o_umai_rcmd_len,
  output logic                               o_umai_wvalid,
  input  logic                               i_umai_wready,
  output logic [BEAT_W-1:0]                  o_umai_wdata,
  output logic                               o_err_proto
);
  logic                                cmd_present, cmd_wr, cmd_room, cmd_acc;
  logic                                grp_valid, grp_acc, pk_room, proto_bad, cfg_bad;
  logic [3:0]                          gstart;
  logic [NumChannels-1:0]              in_range, in_group, wmask;
  logic [NumChannels-1:0][WORD_W-1:0]  words;
  umai_cmd_t                           cmd_pl, wcmd_head, rcmd_head;
  logic                                wq_ready, rq_ready;
  logic                                err_q, err_d;

  // Lane decode: the data group starts one lane later when the first lane carries a command.
  always_comb begin
    cmd_present = 1'b0;
    cmd_wr      = 1'b0;
    cmd_pl      = '0;
    for (int k = 0; k < NumChannels; k++) begin
      if (3'(k) == c_first_chn_id) begin
        cmd_present = i_rx_valid[k] & i_rx_data[k][CMD_BIT];
        cmd_wr      = i_rx_data[k][WR_BIT];
        cmd_pl.len  = i_rx_data[k][37:32];
        cmd_pl.addr = i_rx_data[k][31:0];
      end
    end
    gstart    = {1'b0, c_first_chn_id} + {3'b000, cmd_present};
    cfg_bad   = c_first_chn_id > c_last_chn_id;
    proto_bad = 1'b0;
    in_range  = '0;
    in_group  = '0;
    wmask     = '0;
    words     = '0;
    for (int k = 0; k < NumChannels; k++) begin
      in_range[k] = (3'(k) >= c_first_chn_id) && (3'(k) <= c_last_chn_id);
      in_group[k] = (4'(k) >= gstart) && (3'(k) <= c_last_chn_id);
      words[k]    = i_rx_data[k][WORD_W-1:0];
      // A stray command word on a data lane is dropped rather than packed.
      wmask[k]    = in_group[k] & i_rx_data[k][DVALID_BIT] & ~i_rx_data[k][CMD_BIT];
      if (in_range[k] && i_rx_valid[k]) begin
        if (i_rx_data[k][CMD_BIT] && (3'(k) != c_first_chn_id)) proto_bad = 1'b1;
        if (!i_rx_data[k][CMD_BIT] && (i_rx_data[k][WR_BIT:DVALID_BIT+1] != '0)) proto_bad = 1'b1;
      end
    end
    grp_valid = (|in_group) && ((i_rx_valid | ~in_group) == '1);
  end

  always_comb begin
    cmd_room = cmd_wr ? wq_ready : rq_ready;
    cmd_acc  = ~i_rst & cmd_present & cmd_room;
    grp_acc  = ~i_rst & grp_valid & pk_room;
    for (int k = 0; k < NumChannels; k++) begin
      o_rx_ready[k] = ((3'(k) == c_first_chn_id) && cmd_acc) || (in_group[k] && grp_acc);
    end
    err_d = err_q | proto_bad | cfg_bad;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  gen_fifo #(.Width($bits(umai_cmd_t)), .Depth(CmdDepth)) u_wcmd_fifo (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .push_i  (cmd_acc & cmd_wr),
    .din_i   (cmd_pl),
    .ready_o (wq_ready),
    .valid_o (o_umai_wcmd_valid),
    .pop_i   (i_umai_wcmd_ready),
    .dout_o  (wcmd_head)
  );

  gen_fifo #(.Width($bits(umai_cmd_t)), .Depth(CmdDepth)) u_rcmd_fifo (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .push_i  (cmd_acc & ~cmd_wr),
    .din_i   (cmd_pl),
    .ready_o (rq_ready),
    .valid_o (o_umai_rcmd_valid),
    .pop_i   (i_umai_rcmd_ready),
    .dout_o  (rcmd_head)
  );

  umai_beat_packer #(.NumWords(NumChannels)) u_packer (
    .clk_i    (i_clk),
    .rst_i    (i_rst),
    .push_i   (grp_acc),
    .words_i  (words),
    .wmask_i  (wmask),
    .room_o   (pk_room),
    .wvalid_o (o_umai_wvalid),
    .wready_i (i_umai_wready),
    .wdata_o  (o_umai_wdata)
  );

  assign o_umai_wcmd_addr = wcmd_head.addr;
  assign o_umai_wcmd_len  = wcmd_head.len;
  assign o_umai_rcmd_addr = rcmd_head.addr;
  assign o_umai_rcmd_len  = rcmd_head.len;
  assign o_err_proto      = err_q;
endmodule

// File: tb/tb_umai_link_rx.sv
// Self-checking bench for umai_link_rx: vector table plus scoreboarded corner-case sequences.
module tb_umai_link_rx;
  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       first, last;
  logic [5:0]       rx_valid, rx_ready;
  logic [5:0][71:0] rx_data;
  logic             wcmd_valid, wcmd_ready, rcmd_valid, rcmd_ready, wvalid, wready, err;
  logic [31:0]      wcmd_addr, rcmd_addr;
  logic [5:0]       wcmd_len, rcmd_len;
  logic [511:0]     wdata;

  always #5 clk = ~clk;

  umai_link_rx #(.NumChannels(6), .CmdDepth(2)) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .c_first_chn_id    (first),
    .c_last_chn_id     (last),
    .i_rx_valid        (rx_valid),
    .o_rx_ready        (rx_ready),
    .i_rx_data         (rx_data),
    .o_umai_wcmd_valid (wcmd_valid),
    .i_umai_wcmd_ready (wcmd_ready),
    .o_umai_wcmd_addr  (wcmd_addr),
    .o_umai_wcmd_len   (wcmd_len),
    .o_umai_rcmd_valid (rcmd_valid),
    .i_umai_rcmd_ready (rcmd_ready),
    .o_umai_rcmd_addr  (rcmd_addr),
    .o_umai_rcmd_len   (rcmd_len),
    .o_umai_wvalid     (wvalid),
    .i_umai_wready     (wready),
    .o_umai_wdata      (wdata),
    .o_err_proto       (err)
  );

  int           checks = 0;
  int           failures = 0;
  logic [37:0]  wq[$], rq[$];
  logic [511:0] bq[$];
  logic [63:0]  pend[$];
  logic [63:0]  dseq = 64'hA5A5_0000_0000_0100;
  int           cseq = 0;

  typedef struct {
    logic [2:0] f, l;
    logic [5:0] vm;
    int         cmd;   // 0 none, 1 write, 2 read
    logic [5:0] dv;
    logic [5:0] rdy;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic unexp(input string nm);
    checks++;
    failures++;
    $display("FAIL %s got=output expected=none", nm);
  endtask

  function automatic logic [71:0] cmd_word(input logic wr, input logic [5:0] len, input logic [31:0] addr);
    return {1'b1, wr, 32'b0, len, addr};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_valid = '0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rx_valid = '0;
    rst = 1'b1;
    pend.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drive(input string nm, input logic [2:0] f, input logic [2:0] l, input logic [5:0] vm,
                       input int cmd, input logic [5:0] dv, input logic [5:0] bad, input logic [5:0] exp_rdy);
    logic [31:0]  a;
    logic [5:0]   ln;
    logic [63:0]  w [6];
    logic [511:0] b;
    first    = f;
    last     = l;
    rx_valid = vm;
    a  = 32'h1000_0040 + 32'(cseq) * 32'h40;
    ln = 6'(cseq + 1);
    for (int k = 0; k < 6; k++) begin
      w[k] = dseq + 64'(k);
      if (k == int'(f) && cmd != 0) rx_data[k] = cmd_word(cmd == 1, ln, a);
      else if (bad[k])              rx_data[k] = cmd_word(1'b1, 6'd3, 32'hDEAD_BEEF);
      else                          rx_data[k] = {7'b0, dv[k], w[k]};
    end
    dseq = dseq + 64'h10;
    #2;
    chk(nm, 512'(rx_ready), 512'(exp_rdy));
    if (cmd != 0 && exp_rdy[f]) begin
      if (cmd == 1) wq.push_back({ln, a});
      else          rq.push_back({ln, a});
      cseq++;
    end
    for (int k = 0; k < 6; k++)
      if (exp_rdy[k] && !(k == int'(f) && cmd != 0) && !bad[k] && dv[k]) pend.push_back(w[k]);
    while (pend.size() >= 8) begin
      for (int j = 0; j < 8; j++) b[64*j +: 64] = pend.pop_front();
      bq.push_back(b);
    end
    tick();
    rx_valid = '0;
  endtask

  logic [37:0]  mon_c;
  logic [511:0] mon_b;
  always @(negedge clk) begin
    if (!rst) begin
      if (wcmd_valid && wcmd_ready) begin
        if (wq.size() == 0) unexp("wcmd_unexpected");
        else begin mon_c = wq.pop_front(); chk("wcmd_payload", {wcmd_len, wcmd_addr}, mon_c); end
      end
      if (rcmd_valid && rcmd_ready) begin
        if (rq.size() == 0) unexp("rcmd_unexpected");
        else begin mon_c = rq.pop_front(); chk("rcmd_payload", {rcmd_len, rcmd_addr}, mon_c); end
      end
      if (wvalid && wready) begin
        if (bq.size() == 0) unexp("beat_unexpected");
        else begin mon_b = bq.pop_front(); chk("beat_data", wdata, mon_b); end
      end
    end
  end

  initial begin
    tbl[0] = '{3'd0, 3'd5, 6'h3F, 1, 6'h3E, 6'h3F};
    tbl[1] = '{3'd0, 3'd5, 6'h3F, 0, 6'h1F, 6'h3F};
    tbl[2] = '{3'd0, 3'd5, 6'h3E, 0, 6'h3F, 6'h00};
    tbl[3] = '{3'd0, 3'd5, 6'h3D, 2, 6'h3C, 6'h01};
    tbl[4] = '{3'd1, 3'd3, 6'h3F, 0, 6'h3F, 6'h0E};
    tbl[5] = '{3'd1, 3'd3, 6'h0E, 1, 6'h0C, 6'h0E};
    tbl[6] = '{3'd3, 3'd3, 6'h08, 2, 6'h00, 6'h08};
    tbl[7] = '{3'd2, 3'd4, 6'h1C, 0, 6'h1C, 6'h1C};
    tbl[8] = '{3'd0, 3'd5, 6'h3F, 0, 6'h00, 6'h3F};

    rst = 1'b1; first = 3'd0; last = 3'd5;
    wcmd_ready = 1'b1; rcmd_ready = 1'b1; wready = 1'b1;
    rx_valid = 6'h3F;
    for (int k = 0; k < 6; k++) rx_data[k] = {7'b0, 1'b1, 64'(k)};
    tick();
    tick();
    chk("rst_rx_ready", 512'(rx_ready), 0);
    chk("rst_wcmd_valid", 512'(wcmd_valid), 0);
    chk("rst_rcmd_valid", 512'(rcmd_valid), 0);
    chk("rst_wvalid", 512'(wvalid), 0);
    chk("rst_err", 512'(err), 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_wcmd_addr", 512'(wcmd_addr), 0);
    rx_valid = '0;
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++)
      drive($sformatf("vec%0d_ready", i), tbl[i].f, tbl[i].l, tbl[i].vm, tbl[i].cmd, tbl[i].dv, 6'h00, tbl[i].rdy);
    idle(3);
    chk("vec_no_err", 512'(err), 0);

    // Single active lane: command cycle carries no data.
    do_reset();
    drive("single_cmd_ready", 3'd2, 3'd2, 6'h04, 2, 6'h04, 6'h00, 6'h04);
    chk("single_rcmd_valid", 512'(rcmd_valid), 1);
    for (int i = 0; i < 8; i++) begin
      drive($sformatf("single_data%0d_ready", i), 3'd2, 3'd2, 6'h04, 0, 6'h04, 6'h00, 6'h04);
      if (i == 0) chk("single_rcmd_once", 512'(rcmd_valid), 0);
      if (i == 6) chk("single_no_partial", 512'(wvalid), 0);
    end
    chk("single_beat_valid", 512'(wvalid), 1);
    idle(3);

    // Back-pressure on the write beat output.
    do_reset();
    wready = 1'b0;
    drive("stall_c1", 3'd0, 3'd5, 6'h3F, 0, 6'h3F, 6'h00, 6'h3F);
    drive("stall_c2", 3'd0, 3'd5, 6'h3F, 0, 6'h03, 6'h00, 6'h3F);
    chk("stall_beat1_valid", 512'(wvalid), 1);
    drive("stall_c3_fits", 3'd0, 3'd5, 6'h3F, 0, 6'h3F, 6'h00, 6'h3F);
    drive("stall_c4_blocked", 3'd0, 3'd5, 6'h3F, 0, 6'h3F, 6'h00, 6'h00);
    chk("stall_beat_held", 512'(wvalid), 1);
    wready = 1'b1;
    drive("stall_c5_release", 3'd0, 3'd5, 6'h3F, 0, 6'h3F, 6'h00, 6'h3F);
    idle(3);

    // Full write-command FIFO blocks only the command lane.
    do_reset();
    wcmd_ready = 1'b0;
    drive("fifo_c1", 3'd0, 3'd5, 6'h3F, 1, 6'h3E, 6'h00, 6'h3F);
    drive("fifo_c2", 3'd0, 3'd5, 6'h3F, 1, 6'h3E, 6'h00, 6'h3F);
    chk("fifo_wcmd_valid", 512'(wcmd_valid), 1);
    drive("fifo_full_data_only", 3'd0, 3'd5, 6'h3F, 1, 6'h3E, 6'h00, 6'h3E);
    wcmd_ready = 1'b1;
    drive("fifo_push_while_pop", 3'd0, 3'd5, 6'h01, 1, 6'h00, 6'h00, 6'h01);
    idle(4);

    // Protocol error: stray command word on lane 3, then misconfigured lane range.
    do_reset();
    chk("err_clear_start", 512'(err), 0);
    drive("err_lane3_ready", 3'd0, 3'd5, 6'h3F, 0, 6'h37, 6'h08, 6'h3F);
    chk("err_set", 512'(err), 1);
    idle(3);
    chk("err_sticky", 512'(err), 1);
    rst = 1'b1;
    pend.delete();
    tick();
    chk("err_cleared_by_rst", 512'(err), 0);
    tick();
    rst = 1'b0;
    first = 3'd4; last = 3'd2;
    tick();
    chk("err_cfg_range", 512'(err), 1);
    first = 3'd0; last = 3'd5;
    do_reset();
    chk("err_cfg_cleared", 512'(err), 0);

    // Reset with a partial beat: only fresh words form the next beat.
    drive("partial_c1", 3'd0, 3'd5, 6'h3F, 0, 6'h1F, 6'h00, 6'h3F);
    do_reset();
    drive("fresh_c1", 3'd0, 3'd5, 6'h3F, 0, 6'h3F, 6'h00, 6'h3F);
    drive("fresh_c2", 3'd0, 3'd5, 6'h3F, 0, 6'h03, 6'h00, 6'h3F);
    chk("fresh_beat_valid", 512'(wvalid), 1);
    idle(4);

    chk("wcmd_all_seen", 512'(wq.size()), 0);
    chk("rcmd_all_seen", 512'(rq.size()), 0);
    chk("beats_all_seen", 512'(bq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
